ninjakun_snd_filter: RTL
========================

Name: ninjakun_snd_filter

Overview:
Audio post-processing stage placed directly downstream of the shared-IO PSG mixer output (SNDOUT, 16-bit unsigned sum of six YM2149 channels).
- Decimates the 24 MHz-domain sample stream to a fixed audio rate.
- Removes the DC offset inherent in unsigned PSG summing.
- Applies a first-order IIR low-pass, then volume attenuation and mute.
- Drives the signed 16-bit audio sample to the top-level audio output.

Parameters:
SMPDIV, 500, SHCLK cycles per output sample (24 MHz / 500 = 48 kHz); legal range 4..65535.
DCSHIFT, 10, DC-tracker time constant as a right-shift (2^DCSHIFT samples).
LPSHIFT, 2, low-pass coefficient as a right-shift (alpha = 2^-LPSHIFT).

Ports:
SHCLK  input  1  system clock (24 MHz); sole clock.
RESET_L  input  1  asynchronous active-low reset.
SNDIN  input  16  unsigned PSG mix; sampled only on the divider tick.
VOL  input  2  attenuation: output arithmetic right-shifted by VOL (0 = full, 3 = -18 dB).
MUTE  input  1  1 = force output sample to 0.
SNDOUT  output  16  signed filtered sample (two's complement).
SMPSTB  output  1  one-cycle pulse in the cycle SNDOUT takes a new value.
CLIP  output  1  sticky flag: set when any DC-stage saturation occurs; cleared only by reset.

Behaviour:
Clock and reset:
- Single clock SHCLK. Reset is asynchronous and active-low on RESET_L.
- While RESET_L = 0, all registers clear: divider = 0, dc_acc = 0, lp = 0, pipeline valid bits = 0, SNDOUT = 0, SMPSTB = 0, CLIP = 0.

Divider:
- Counter runs 0..SMPDIV-1 and wraps to 0.
- tick = (counter == SMPDIV-1).
- The first tick after reset release occurs SMPDIV cycles after release.

Stage 0 (on tick, cycle T):
- x = {~SNDIN[15], SNDIN[14:0]}, i.e. SNDIN - 32768 as signed 16-bit.
- Set v0.

Stage 1, DC removal (cycle T+1, when v0):
- dc = dc_acc >>> DCSHIFT (arithmetic), taken from the pre-update accumulator.
- y1 = sat16(x - dc), computed in 17 bits.
- dc_acc <= dc_acc + x - dc. dc_acc is signed, 17+DCSHIFT bits wide, and never overflows.
- If saturation occurs, set CLIP.
- Set v1.

Stage 2, low-pass (cycle T+2, when v1):
- lp <= lp + ((y1 - lp) >>> LPSHIFT).
- Difference is 17-bit signed. The result always fits in 16 bits, so no saturation is needed.
- Set v2.

Stage 3, output (cycle T+3, when v2):
- SNDOUT <= MUTE ? 0 : (lp >>> VOL).
- SMPSTB = 1 for exactly this cycle.
- VOL and MUTE are sampled only here; changes take effect on the next sample with no glitch.

Timing and boundary conditions:
- Latency is tick to SMPSTB = 3 cycles.
- Pipeline depth 3 < SMPDIV, so stages never overlap.
- SNDOUT holds its value between strobes.
- SNDIN changes between ticks are ignored.
- Reset asserted mid-pipeline: all valid bits clear and no SMPSTB is emitted. After release, output resumes only after the next full divider period.
- MUTE does not freeze the filters: dc_acc and lp keep updating, so unmute is continuous.
- sat16 clamps to +32767 / -32768.

Test Plan:
1. Reset/idle: hold RESET_L = 0 for 10 cycles, then release with SNDIN = 0x8000. SNDOUT = 0, CLIP = 0 throughout; SMPSTB pulses every 500 cycles, first pulse at cycle 503 after release.
2. Step response (defaults, VOL = 0): settle at SNDIN = 0x8000, then step to 0xC000. The next two strobes give SNDOUT = 4096 then 7164. After about 10,000 samples, |SNDOUT| < 64 (DC removed).
3. Saturation: hold SNDIN = 0x0000 for 20,000 samples, then step to 0xFFFF. The first post-step y1 clamps to +32767 and CLIP goes 1 and stays 1. SNDOUT is monotonic rising over the next 4 strobes.
4. Volume/mute: with lp steady at 8000, VOL = 2 gives SNDOUT = 2000. Assert MUTE mid-period: the next strobe gives 0. Deassert MUTE: the next strobe gives 2000, with no discontinuity in the internal lp.
5. Reset mid-operation: assert RESET_L = 0 at T+1 after a tick. No SMPSTB at T+3; SNDOUT = 0, CLIP = 0. Normal cadence resumes SMPDIV + 3 cycles after release.
6. Input ignored between ticks: toggle SNDIN every cycle except hold 0xA000 on tick cycles. Output matches the constant-0xA000 reference run bit-exactly.

Source files
------------

// File: rtl/ninjakun_snd_filter.sv
// Audio post-processing after the PSG mixer: decimate, remove DC, low-pass, then volume and mute.
// Latency is 3 cycles from divider tick to SMPSTB. There is no backpressure: the stage runs free once per SMPDIV cycles.
module ninjakun_snd_filter #(
    parameter int unsigned SMPDIV  = 500,
    parameter int unsigned DCSHIFT = 10,
    parameter int unsigned LPSHIFT = 2
) (
    input  logic        SHCLK,
    input  logic        RESET_L,
    input  logic [15:0] SNDIN,
    input  logic [1:0]  VOL,
    input  logic        MUTE,
    output logic [15:0] SNDOUT,
    output logic        SMPSTB,
    output logic        CLIP
);

    localparam int unsigned ACCW = 17 + DCSHIFT;

    logic [15:0]             div_q, div_d;
    logic                    tick;
    logic signed [15:0]      x_q, x_d;
    logic                    v0_q, v0_d;
    logic signed [15:0]      y1_q, y1_d;
    logic                    v1_q, v1_d;
    logic signed [ACCW-1:0]  dc_acc_q, dc_acc_d;
    logic                    clip_q, clip_d;
    logic signed [15:0]      lp_q, lp_d;
    logic                    v2_q, v2_d;
    logic [15:0]             out_q, out_d;
    logic                    stb_q, stb_d;

    logic signed [ACCW-1:0]  x_w, dc_w, diff_w;
    logic                    sat_hi, sat_lo;
    logic signed [16:0]      y1_w, lp_w, lp_step;

    always_comb begin
        tick     = (div_q == 16'(SMPDIV - 1));
        div_d    = tick ? '0 : div_q + 16'd1;

        // Stage 0: offset-binary to two's complement by flipping the MSB
        x_d      = x_q;
        v0_d     = tick;
        if (tick) begin
            x_d = {~SNDIN[15], SNDIN[14:0]};
        end

        // Stage 1: DC tracker; the accumulator integrates the unsaturated difference
        x_w      = ACCW'(x_q);
        dc_w     = dc_acc_q >>> DCSHIFT;
        diff_w   = x_w - dc_w;
        sat_hi   = (diff_w > ACCW'(32767));
        sat_lo   = (diff_w < ACCW'(-32768));
        y1_d     = y1_q;
        dc_acc_d = dc_acc_q;
        clip_d   = clip_q;
        v1_d     = v0_q;
        if (v0_q) begin
            if (sat_hi) begin
                y1_d = 16'sh7FFF;
            end else if (sat_lo) begin
                y1_d = 16'sh8000;
            end else begin
                y1_d = 16'(diff_w);
            end
            dc_acc_d = dc_acc_q + diff_w;
            clip_d   = clip_q | sat_hi | sat_lo;
        end

        // Stage 2: one-pole low-pass
        y1_w     = 17'(y1_q);
        lp_w     = 17'(lp_q);
        lp_step  = (y1_w - lp_w) >>> LPSHIFT;
        lp_d     = lp_q;
        v2_d     = v1_q;
        if (v1_q) begin
            lp_d = 16'(lp_w + lp_step);
        end

        // Stage 3: volume and mute only touch the output, never the filter state
        out_d    = out_q;
        stb_d    = v2_q;
        if (v2_q) begin
            out_d = MUTE ? '0 : 16'(lp_q >>> VOL);
        end
    end

    always_ff @(posedge SHCLK or negedge RESET_L) begin
        if (!RESET_L) begin
            div_q    <= '0;
            x_q      <= '0;
            v0_q     <= 1'b0;
            y1_q     <= '0;
            v1_q     <= 1'b0;
            dc_acc_q <= '0;
            clip_q   <= 1'b0;
            lp_q     <= '0;
            v2_q     <= 1'b0;
            out_q    <= '0;
            stb_q    <= 1'b0;
        end else begin
            div_q    <= div_d;
            x_q      <= x_d;
            v0_q     <= v0_d;
            y1_q     <= y1_d;
            v1_q     <= v1_d;
            dc_acc_q <= dc_acc_d;
            clip_q   <= clip_d;
            lp_q     <= lp_d;
            v2_q     <= v2_d;
            out_q    <= out_d;
            stb_q    <= stb_d;
        end
    end

    assign SNDOUT = out_q;
    assign SMPSTB = stb_q;
    assign CLIP   = clip_q;

endmodule
